// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 16-bit external SRAM controller.
//   state_t            : controller sequence IDLE -> LO -> HI -> WAIT -> DONE
//   SRAM_ADDR_W/DATA_W : SRAM half-word address and data widths
//   WORD_W             : pipeline word width
//   IDX_W              : width of the word index (one SRAM address bit less)
//   WAIT_CNT_W         : settle counter width (WAIT_CYCLES range 1..15)
//   DEFAULT_ADDR_BASE  : byte address that maps to SRAM word 0
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_W       = SRAM_ADDR_W - 1;
  localparam int unsigned WAIT_CNT_W  = 4;

  localparam logic [WORD_W-1:0] DEFAULT_ADDR_BASE = 32'd1024;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry buffer holding the most recently read word, used to answer a
// repeated read without touching the SRAM. Only present when the
// SRAM_READ_BUFFER_EN macro is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears valid)
//   fill_en    : load tag/data and mark valid (completed read)
//   upd_en     : refresh data if wr_idx matches the buffered tag (write)
//   wr_idx     : word index for fill/update
//   wr_data    : word for fill/update
//   lookup_idx : index being requested
//   hit        : buffered word matches lookup_idx
//   rd_data    : buffered word
`ifdef SRAM_READ_BUFFER_EN
module sram_read_buffer
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_en,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              hit,
  output logic [WORD_W-1:0] rd_data
);

  logic              valid;
  logic [IDX_W-1:0]  tag;
  logic [WORD_W-1:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= wr_idx;
      data  <= wr_data;
    end else if (upd_en && valid && (tag == wr_idx)) begin
      data <= wr_data;
    end
  end

  assign hit     = valid && (tag == lookup_idx);
  assign rd_data = data;

endmodule
`endif

// File: rtl/sram_controller.sv
// Initiator side of the 16-bit external SRAM interface. Each 32-bit read or
// write request becomes two SRAM accesses (low half, then high half) followed
// by WAIT_CYCLES settle cycles; ready stays low until the access completes.
// Optional feature macro: SRAM_READ_BUFFER_EN (one-entry read buffer).
// Parameters:
//   ADDR_BASE   : byte address mapping to SRAM word 0
//   WAIT_CYCLES : settle cycles after the high-half access (1..15)
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wr_en/rd_en : request strobes, held until ready (write wins)
//   address     : word-aligned byte address
//   wdata/rdata : write data in, registered read data out
//   ready       : low while a request is in progress
//   SRAM_ADDR   : SRAM half-word address
//   SRAM_WE_N   : active-low SRAM write enable
//   SRAM_DQ     : bidirectional SRAM data bus
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

  state_t                  state, state_nxt;
  logic                    req;
  logic                    op_wr;
  logic [IDX_W-1:0]        idx_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    dq_oe;
  logic [SRAM_DATA_W-1:0]  dq_out;
  logic [WORD_W-1:0]       offset;
  logic [IDX_W-1:0]        idx_in;
  logic                    unused_offset_bits;
  logic                    buf_hit;
  logic [WORD_W-1:0]       buf_data;

  assign req    = wr_en | rd_en;
  // Upper offset bits are dropped, so addresses outside the window wrap.
  assign offset = address - ADDR_BASE;
  assign idx_in = offset[18:2];
  assign unused_offset_bits = ^{offset[WORD_W-1:19], offset[1:0]};

`ifdef SRAM_READ_BUFFER_EN
  sram_read_buffer u_read_buffer (
    .clk       (clk),
    .rst       (rst),
    .fill_en   ((state == HI) && !op_wr),
    .upd_en    ((state == HI) && op_wr),
    .wr_idx    (idx_q),
    .wr_data   (op_wr ? wdata_q : {SRAM_DQ, rdata[SRAM_DATA_W-1:0]}),
    .lookup_idx(idx_in),
    .hit       (buf_hit),
    .rd_data   (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    dq_oe     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) state_nxt = (!wr_en && buf_hit) ? DONE : LO;
      end
      LO: begin
        dq_oe     = op_wr;
        state_nxt = HI;
      end
      HI: begin
        dq_oe     = op_wr;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dq_out  = (state == HI) ? wdata_q[WORD_W-1:SRAM_DATA_W] : wdata_q[SRAM_DATA_W-1:0];
  assign SRAM_DQ = dq_oe ? dq_out : 'z;

  // SRAM_ADDR / SRAM_WE_N are registered, so they are loaded on the edge
  // entering the state in which they must be valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= '0;
      rdata     <= '0;
      wait_cnt  <= '0;
      op_wr     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= wr_en;
            idx_q   <= idx_in;
            wdata_q <= wdata;
            if (state_nxt == LO) begin
              SRAM_ADDR <= {idx_in, 1'b0};
              SRAM_WE_N <= !wr_en;
            end else begin
              rdata <= buf_data;
            end
          end
        end
        LO: begin
          SRAM_ADDR <= {idx_q, 1'b1};
          if (!op_wr) rdata[SRAM_DATA_W-1:0] <= SRAM_DQ;
        end
        HI: begin
          SRAM_WE_N <= 1'b1;
          wait_cnt  <= WAIT_CNT_W'(WAIT_CYCLES - 1);
          if (!op_wr) rdata[WORD_W-1:SRAM_DATA_W] <= SRAM_DQ;
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: an SRAM device model on the pins,
// a cycle-timeline reference model checked every cycle, and directed
// requests with hand-computed expected values.
module tb_sram_controller;

  localparam int unsigned     W       = 2;
  localparam int              ACC_LEN = 4 + W;
  localparam logic [31:0]     BASE    = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  wire  [15:0] SRAM_DQ;

  sram_controller #(.ADDR_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ(SRAM_DQ)
  );

  always #5 clk = ~clk;

  // SRAM device: drives the bus whenever not being written.
  logic [15:0] mem [0:255];
  logic        mem_init = 1'b1;
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(32'hA500 + i);
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
    end
  end

  int unsigned n_cmp = 0, n_bad = 0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: an access is a timeline of cycles counted from the
  // cycle the request is seen (offset 0); offsets 1/2 are the low/high SRAM
  // cycles and offset len-1 is the single ready cycle.
  logic [15:0] ref_mem [0:255];
  bit          busy = 1'b0, m_wr = 1'b0, m_hit = 1'b0;
  int          off = 0;
  logic [16:0] m_idx = '0;
  logic [31:0] m_wdata = '0, exp_rdata = '0;
  logic [17:0] exp_addr = '0, prev_addr = '0;
  int unsigned we_low_cnt = 0, ready_hi_cnt = 0, addr_chg_cnt = 0;
`ifdef SRAM_READ_BUFFER_EN
  bit          bv = 1'b0;
  logic [16:0] btag = '0;
  logic [31:0] bdata = '0;
`endif

  task automatic model_step();
    logic [31:0] diff;
    logic        in_acc, e_ready, e_we_n, hi;
    logic [15:0] e_dq;
    int          len;
    if (!busy && (wr_en || rd_en)) begin
      busy    = 1'b1;
      off     = 0;
      m_wr    = wr_en;
      diff    = address - BASE;
      m_idx   = diff[18:2];
      m_wdata = wdata;
      m_hit   = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
      if (!wr_en && bv && btag == m_idx) m_hit = 1'b1;
`endif
    end
    len     = m_hit ? 2 : ACC_LEN;
    hi      = (off == 2);
    in_acc  = busy && !m_hit && (off == 1 || off == 2);
    e_ready = !busy || (off == len - 1);
    e_we_n  = !(in_acc && m_wr);
    if (in_acc) exp_addr = {m_idx, hi};
    e_dq = e_we_n ? ref_mem[exp_addr[7:0]] : (hi ? m_wdata[31:16] : m_wdata[15:0]);

    check("ready", ready, e_ready);
    check("SRAM_WE_N", SRAM_WE_N, e_we_n);
    check("SRAM_ADDR", SRAM_ADDR, exp_addr);
    check("SRAM_DQ", SRAM_DQ, e_dq);
    check("rdata", rdata, exp_rdata);

    if (in_acc) begin
      if (m_wr) ref_mem[exp_addr[7:0]] = e_dq;
      else if (hi) exp_rdata[31:16] = ref_mem[exp_addr[7:0]];
      else exp_rdata[15:0] = ref_mem[exp_addr[7:0]];
    end
`ifdef SRAM_READ_BUFFER_EN
    if (busy && m_hit && off == 0) exp_rdata = bdata;
    if (busy && !m_hit && off == 2) begin
      if (!m_wr) begin
        bv = 1'b1; btag = m_idx; bdata = exp_rdata;
      end else if (bv && btag == m_idx) begin
        bdata = m_wdata;
      end
    end
`endif
    if (busy) begin
      off++;
      if (off == len) busy = 1'b0;
    end
    if (rst) begin
      busy = 1'b0; exp_rdata = '0; exp_addr = '0;
`ifdef SRAM_READ_BUFFER_EN
      bv = 1'b0;
`endif
    end
    if (SRAM_WE_N === 1'b0) we_low_cnt++;
    if (ready === 1'b1) ready_hi_cnt++;
    if (SRAM_ADDR !== prev_addr) addr_chg_cnt++;
    prev_addr = SRAM_ADDR;
  endtask

  // Called just after a rising edge (cycle 0). mode 1 scrambles address and
  // wdata in cycle 1; mode 2 drops the request in cycle 1. Returns the cycle
  // in which ready was seen high (-1 if never within the budget).
  task automatic run_req(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input int mode, input bit hold,
                         output int cyc);
    wr_en = w; rd_en = r; address = a; wdata = d;
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 1 && mode == 1) begin address = a ^ 32'h40; wdata = ~d; end
      if (i == 1 && mode == 2) begin wr_en = 1'b0; rd_en = 1'b0; end
      @(negedge clk);
      if (ready === 1'b1) begin cyc = i; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!hold) begin wr_en = 1'b0; rd_en = 1'b0; end
  endtask

  initial begin
    int cyc, snap;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(32'hA500 + i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;
    fork
      forever begin @(negedge clk); model_step(); end
    join_none

    // Reset state: controller released the bus, device shows word 0.
    @(negedge clk); #1;
    check("rst_ready", ready, 1'b1);
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_addr", SRAM_ADDR, 18'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dq_released", SRAM_DQ, 16'hA500);
    @(posedge clk); #1;

    // Write 1024, address/wdata scrambled mid-access.
    snap = we_low_cnt;
    run_req(1, 0, 32'd1024, 32'hDEADBEEF, 1, 0, cyc);
    check("wr_latency", cyc, 5);
    check("wr_we_low_cycles", we_low_cnt - snap, 2);
    check("wr_mem0", mem[0], 16'hBEEF);
    check("wr_mem1", mem[1], 16'hDEAD);

    // Read it back with the request dropped after one cycle.
    run_req(0, 1, 32'd1024, 32'h0, 2, 0, cyc);
    check("rd_latency", cyc, 5);
    check("rd_data", rdata, 32'hDEADBEEF);

    // Both strobes: write wins; rdata holds across the write.
    run_req(1, 1, 32'd1028, 32'h12345678, 0, 0, cyc);
    check("both_mem2", mem[2], 16'h5678);
    check("both_mem3", mem[3], 16'h1234);
    check("both_rdata_hold", rdata, 32'hDEADBEEF);

    // Back-to-back reads with the request held through DONE.
    snap = ready_hi_cnt;
    run_req(0, 1, 32'd1032, 32'h0, 0, 1, cyc);
    check("b2b_lat1", cyc, 5);
    check("b2b_data1", rdata, 32'hA505A504);
    run_req(0, 1, 32'd1036, 32'h0, 0, 0, cyc);
    check("b2b_lat2", cyc, 5);
    check("b2b_data2", rdata, 32'hA507A506);
    check("b2b_ready_pulses", ready_hi_cnt - snap, 2);

    // Address below the base wraps to the top of the SRAM.
    run_req(1, 0, 32'd1020, 32'hA1B2C3D4, 0, 0, cyc);
    check("wrap_mem_lo", mem[8'hFE], 16'hC3D4);
    check("wrap_mem_hi", mem[8'hFF], 16'hA1B2);
    check("wrap_addr", SRAM_ADDR, 18'h3FFFF);

    // Reset lands on the edge that would enter HI: the low half is written,
    // the high half never gets its write cycle.
    wr_en = 1'b1; address = 32'd1024; wdata = 32'h11112222;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("mrst_we_n", SRAM_WE_N, 1'b1);
    check("mrst_ready", ready, 1'b1);
    check("mrst_rdata", rdata, 32'h0);
    check("mrst_addr", SRAM_ADDR, 18'h0);
    check("mrst_dq_released", SRAM_DQ, 16'h2222);
    check("mrst_mem0", mem[0], 16'h2222);
    check("mrst_mem1", mem[1], 16'hDEAD);
    @(posedge clk); #1;

`ifdef SRAM_READ_BUFFER_EN
    run_req(0, 1, 32'd1024, 32'h0, 0, 0, cyc);
    check("buf_fill_lat", cyc, 5);
    check("buf_fill_data", rdata, 32'hDEAD2222);
    snap = addr_chg_cnt;
    run_req(0, 1, 32'd1024, 32'h0, 0, 0, cyc);
    check("buf_hit_lat", cyc, 1);
    check("buf_hit_no_sram", addr_chg_cnt - snap, 0);
    check("buf_hit_data", rdata, 32'hDEAD2222);
    run_req(1, 0, 32'd1024, 32'h55AA33CC, 0, 0, cyc);
    run_req(0, 1, 32'd1024, 32'h0, 0, 0, cyc);
    check("buf_upd_lat", cyc, 1);
    check("buf_upd_data", rdata, 32'h55AA33CC);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
